// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, instruction codes and instruction decode.
package tap_pkg;

  typedef enum logic [3:0] {
    StEx2Dr   = 4'h0,
    StEx1Dr   = 4'h1,
    StShDr    = 4'h2,
    StPauseDr = 4'h3,
    StSelIr   = 4'h4,
    StUpdDr   = 4'h5,
    StCapDr   = 4'h6,
    StSelDr   = 4'h7,
    StEx2Ir   = 4'h8,
    StEx1Ir   = 4'h9,
    StShIr    = 4'hA,
    StPauseIr = 4'hB,
    StRti     = 4'hC,
    StUpdIr   = 4'hD,
    StCapIr   = 4'hE,
    StTlr     = 4'hF
  } tap_state_e;

  localparam logic [1:0] EXTEST = 2'b00;
  localparam logic [1:0] SAMPLE = 2'b01;
  localparam logic [1:0] BYPASS = 2'b11;

  // EXTEST and SAMPLE are the only codes whose bits above bit 0 are all zero.
  function automatic logic isChainInstr(input logic [31:0] instr);
    return (instr | 32'd1) == 32'(SAMPLE);
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state register with TMS-driven next-state selection.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic       tms,
  output tap_state_e state
);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state <= StTlr;
    end else begin
      unique case (state)
        StTlr:     state <= tms ? StTlr   : StRti;
        StRti:     state <= tms ? StSelDr : StRti;
        StSelDr:   state <= tms ? StSelIr : StCapDr;
        StCapDr:   state <= tms ? StEx1Dr : StShDr;
        StShDr:    state <= tms ? StEx1Dr : StShDr;
        StEx1Dr:   state <= tms ? StUpdDr : StPauseDr;
        StPauseDr: state <= tms ? StEx2Dr : StPauseDr;
        StEx2Dr:   state <= tms ? StUpdDr : StShDr;
        StUpdDr:   state <= tms ? StSelDr : StRti;
        StSelIr:   state <= tms ? StTlr   : StCapIr;
        StCapIr:   state <= tms ? StEx1Ir : StShIr;
        StShIr:    state <= tms ? StEx1Ir : StShIr;
        StEx1Ir:   state <= tms ? StUpdIr : StPauseIr;
        StPauseIr: state <= tms ? StEx2Ir : StPauseIr;
        StEx2Ir:   state <= tms ? StUpdIr : StShIr;
        StUpdIr:   state <= tms ? StSelDr : StRti;
        default:   state <= StTlr;
      endcase
    end
  end

endmodule

// File: rtl/tap_controller.sv
// TAP controller: instruction/bypass registers and boundary-scan chain control decode.
module tap_controller
  import tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH = 2
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       tdoEn,
  output logic       bsrTdi,
  input  logic       bsrTdo,
  output logic       bsrCe,
  output logic       shiftLoad,
  output logic       update,
  output logic       testNorm,
  output logic [3:0] state
);

  tap_state_e          fsm_state;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_sh;
  logic                bypass;
  logic                chain_sel;

  tap_fsm u_tap_fsm (
    .clk   (clk),
    .rst_l (rst_l),
    .tms   (tms),
    .state (fsm_state)
  );

  assign state     = fsm_state;
  assign bsrTdi    = tdi;
  assign chain_sel = isChainInstr(32'(ir));

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      ir     <= '1;
      ir_sh  <= '0;
      bypass <= 1'b0;
    end else begin
      case (fsm_state)
        StTlr: begin
          ir     <= '1;
          ir_sh  <= '0;
          bypass <= 1'b0;
        end
        StCapIr: ir_sh  <= IR_WIDTH'(1);
        StShIr:  ir_sh  <= {tdi, ir_sh[IR_WIDTH-1:1]};
        StUpdIr: ir     <= ir_sh;
        StCapDr: bypass <= 1'b0;
        StShDr: begin
          if (!chain_sel) bypass <= tdi;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tdoEn     = (fsm_state == StShIr) || (fsm_state == StShDr);
    shiftLoad = (fsm_state == StShDr);
    bsrCe     = chain_sel && ((fsm_state == StCapDr) || (fsm_state == StShDr));
    // Reset in UpdDR suppresses the strobe so the cells never latch.
    update    = chain_sel && (fsm_state == StUpdDr) && rst_l;
    // ir is only restored to BYPASS on leaving TLR, so TLR masks it directly.
    testNorm  = (32'(ir) == 32'(EXTEST)) && (fsm_state != StTlr);
    tdo       = 1'b0;
    if (fsm_state == StShIr) begin
      tdo = ir_sh[0];
    end else if (fsm_state == StShDr) begin
      tdo = chain_sel ? bsrTdo : bypass;
    end
  end

endmodule
